// File: rtl/c64_bus_dma_port_pkg.sv
// Shared definitions for the C64 expansion-port DMA responder and the DMA engine.
`default_nettype none

package c64_bus_dma_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WAITBA = 3'd2,
    ST_CYCLE  = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // dma_rw polarity: 1 = write to C64, 0 = read from C64
  localparam logic RW_WRITE = 1'b1;

  function automatic logic pending(input logic req, input logic ack);
    return req != ack;
  endfunction

endpackage

`default_nettype wire

// File: rtl/c64_bus_dma_port_phi2_edge_sync.sv
// Synchronizes async phi2/BA into clk and derives phi2 rise/fall strobes and phi2tick.
`default_nettype none

module phi2_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic phi2_i,
  input  logic ba_i,
  output logic rise_o,
  output logic fall_o,
  output logic ba_o,
  output logic phi2tick_o
);

  logic [SYNC_STAGES-1:0] phi2_sync_q;
  logic [SYNC_STAGES-1:0] ba_sync_q;
  logic                   phi2_prev_q;
  logic                   phi2tick_q;
  logic                   phi2_s;

  assign phi2_s = phi2_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      phi2_sync_q <= '0;
      ba_sync_q   <= '0;
      phi2_prev_q <= 1'b0;
      phi2tick_q  <= 1'b0;
    end else begin
      phi2_sync_q <= {phi2_sync_q[SYNC_STAGES-2:0], phi2_i};
      ba_sync_q   <= {ba_sync_q[SYNC_STAGES-2:0], ba_i};
      phi2_prev_q <= phi2_s;
      phi2tick_q  <= rise_o;
    end
  end

  assign rise_o     = phi2_s & ~phi2_prev_q;
  assign fall_o     = ~phi2_s & phi2_prev_q;
  assign ba_o       = ba_sync_q[SYNC_STAGES-1];
  assign phi2tick_o = phi2tick_q;

endmodule

`default_nettype wire

// File: rtl/c64_bus_dma_port.sv
// Responder for the dma_req/dma_ack toggle handshake; runs each request as a real C64 bus cycle.
`default_nettype none

module c64_bus_dma_port
  import c64_bus_dma_port_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int WRITE_DELAY    = 4,
  parameter int READ_SAMPLE    = 20,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_d,
  input  logic        dma_rw,
  input  logic        dma_req,
  output logic        dma_ack,
  output logic [7:0]  dma_q,
  input  logic        phi2_in,
  input  logic        ba_in,
  output logic        bus_dma_n,
  output logic [15:0] bus_a,
  output logic        bus_a_oe,
  output logic        bus_rw_n,
  output logic        bus_rw_oe,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  output logic        phi2tick
);

  logic rise, fall, ba_sync;

  phi2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .phi2_i     (phi2_in),
    .ba_i       (ba_in),
    .rise_o     (rise),
    .fall_o     (fall),
    .ba_o       (ba_sync),
    .phi2tick_o (phi2tick)
  );

  state_e      state_q, state_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d, idle_inc;
  logic [7:0]  cnt_q, cnt_d;
  logic        dma_n_q, dma_n_d;
  logic        a_oe_q, a_oe_d, rw_oe_q, rw_oe_d, d_oe_q, d_oe_d;
  logic        rw_n_q, rw_n_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic        ack_q, ack_toggle, start;

  assign idle_inc = (idle_cnt_q == 4'hF) ? idle_cnt_q : idle_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    dma_n_d    = dma_n_q;
    a_oe_d     = a_oe_q;
    rw_oe_d    = rw_oe_q;
    d_oe_d     = d_oe_q;
    rw_n_d     = rw_n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_toggle = 1'b0;
    start      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dma_n_d = 1'b1;
        if (pending(dma_req, ack_q)) state_d = ST_ARM;
      end
      ST_ARM: begin
        // Assert /DMA at a fall so a full phi2-low precedes the first cycle
        if (fall) begin
          dma_n_d = 1'b0;
          state_d = ST_WAITBA;
        end
      end
      ST_WAITBA: begin
        if (rise && ba_sync) start = 1'b1;
      end
      ST_CYCLE: begin
        if (!rw_n_q && cnt_q == 8'(WRITE_DELAY - 1)) d_oe_d = 1'b1;
        if (rw_n_q && cnt_q == 8'(READ_SAMPLE)) rdata_d = bus_d_in;
        if (fall) begin
          a_oe_d     = 1'b0;
          rw_oe_d    = 1'b0;
          d_oe_d     = 1'b0;
          ack_toggle = 1'b1;
          idle_cnt_d = 4'd0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rise && pending(dma_req, ack_q)) begin
          if (ba_sync) start = 1'b1;
          else         state_d = ST_WAITBA;
        end else if (fall) begin
          idle_cnt_d = idle_inc;
          if (idle_inc >= 4'(RELEASE_CYCLES)) begin
            dma_n_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Request fields are captured only here; cnt_q then counts clks since the synced rise
    if (start) begin
      state_d = ST_CYCLE;
      a_oe_d  = 1'b1;
      rw_oe_d = 1'b1;
      addr_d  = dma_a;
      rw_n_d  = (dma_rw != RW_WRITE);
      wdata_d = dma_d;
      cnt_d   = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= 4'd0;
      cnt_q      <= 8'd0;
      dma_n_q    <= 1'b1;
      a_oe_q     <= 1'b0;
      rw_oe_q    <= 1'b0;
      d_oe_q     <= 1'b0;
      rw_n_q     <= 1'b1;
      addr_q     <= 16'd0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      cnt_q      <= cnt_d;
      dma_n_q    <= dma_n_d;
      a_oe_q     <= a_oe_d;
      rw_oe_q    <= rw_oe_d;
      d_oe_q     <= d_oe_d;
      rw_n_q     <= rw_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Ack survives reset so the engine can realign its request to it
  always_ff @(posedge clk) begin
    if (!reset && ack_toggle) ack_q <= ~ack_q;
  end

  assign dma_ack   = ack_q;
  assign dma_q     = rdata_q;
  assign bus_dma_n = dma_n_q;
  assign bus_a     = addr_q;
  assign bus_a_oe  = a_oe_q;
  assign bus_rw_n  = rw_n_q;
  assign bus_rw_oe = rw_oe_q;
  assign bus_d     = wdata_q;
  assign bus_d_oe  = d_oe_q;

endmodule

`default_nettype wire
